// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg -- shared widths, opcode/state encodings and instruction field positions
// Rev 1.0
package alu_pkg;

  localparam int DATA_W  = 18;
  localparam int INSTR_W = 11;

  // instr = {op[10:9], rd[8:6], rs1[5:3], rs2[2:0]}
  localparam int OP_LSB  = 9;
  localparam int RD_LSB  = 6;
  localparam int RS1_LSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_AND  = 2'b01,
    OP_NAND = 2'b10,
    OP_NOR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WB    = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// alu_regfile -- NREGS x DATA_W register file, one sync write port, three async reads
// Rev 1.0; macro ALU_STAGE_REG0_ZERO_EN hardwires entry 0 to zero
module alu_regfile #(
  parameter int DATA_W = 18,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [AW-1:0]     raddr3,
  output logic [DATA_W-1:0] rdata3
);

  logic [DATA_W-1:0] mem [NREGS];
  logic              we_eff;

`ifdef ALU_STAGE_REG0_ZERO_EN
  // entry 0 is cleared by reset and never written, so it always reads zero
  assign we_eff = we && (waddr != '0);
`else
  assign we_eff = we;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we_eff) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
  assign rdata3 = mem[raddr3];

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// alu_operand_stage -- register-file operand fetch, ALU issue and writeback (IDLE/ISSUE/WB)
// Rev 1.0; optional ALU_STAGE_REG0_ZERO_EN (see alu_regfile)
module alu_operand_stage #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_valid,
  input  logic [AW-1:0]                ld_addr,
  input  logic [DATA_W-1:0]            ld_data,
  output logic                         ld_ready,
  input  logic                         instr_valid,
  input  logic [alu_pkg::INSTR_W-1:0]  instr,
  output logic                         instr_ready,
  output logic [DATA_W-1:0]            alu_a,
  output logic [DATA_W-1:0]            alu_b,
  output logic [1:0]                   alu_select,
  input  logic [DATA_W-1:0]            alu_result,
  input  logic                         alu_carry,
  output logic                         done,
  output logic                         carry_flag,
  output logic                         zero_flag,
  input  logic [AW-1:0]                dbg_addr,
  output logic [DATA_W-1:0]            dbg_data
);

  import alu_pkg::*;

  state_e            state, state_next;
  op_e               op_q;
  logic [AW-1:0]     rd_q;
  logic              ld_fire, instr_fire, in_wb;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [AW-1:0]     rs1_addr, rs2_addr, rd_addr;
  logic [DATA_W-1:0] rs1_data, rs2_data;

  assign rs1_addr = instr[RS1_LSB +: AW];
  assign rs2_addr = instr[RS2_LSB +: AW];
  assign rd_addr  = instr[RD_LSB +: AW];

  assign ld_ready    = (state == ST_IDLE);
  assign instr_ready = (state == ST_IDLE) && !ld_valid;
  assign ld_fire     = ld_valid && ld_ready;
  assign instr_fire  = instr_valid && instr_ready;
  assign in_wb       = (state == ST_WB);
  assign done        = in_wb;
  assign alu_select  = op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (instr_fire) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WB;
      ST_WB:    state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Loads only happen in IDLE and writeback only in WB, so the two never collide
  always_comb begin
    rf_we    = ld_fire || in_wb;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (in_wb) begin
      rf_waddr = rd_q;
      rf_wdata = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a <= '0;
      alu_b <= '0;
      op_q  <= OP_ADD;
      rd_q  <= '0;
    end else if (instr_fire) begin
      alu_a <= rs1_data;
      alu_b <= rs2_data;
      op_q  <= op_e'(instr[OP_LSB +: 2]);
      rd_q  <= rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (in_wb) begin
      zero_flag  <= (alu_result == '0);
      carry_flag <= (op_q == OP_ADD) ? alu_carry : 1'b0;
    end
  end

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (rs1_addr),
    .rdata1 (rs1_data),
    .raddr2 (rs2_addr),
    .rdata2 (rs2_data),
    .raddr3 (dbg_addr),
    .rdata3 (dbg_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// tb_alu_operand_stage -- self-checking bench: directed cases plus random load/instruction mix
// Rev 1.0
module tb_alu_operand_stage;

  localparam int DW = 18;
  localparam logic [DW-1:0] ALL1 = 18'h3FFFF;
`ifdef ALU_STAGE_REG0_ZERO_EN
  localparam bit Z0 = 1'b1;
`else
  localparam bit Z0 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic [2:0]    ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          instr_valid;
  logic [10:0]   instr;
  logic          instr_ready;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [1:0]    alu_select;
  logic          alu_carry;
  logic          done, carry_flag, zero_flag;
  logic [2:0]    dbg_addr;
  logic [DW-1:0] dbg_data;

  int errs   = 0;
  int checks = 0;

  // reference model state
  logic [DW-1:0] m [8];
  logic          mz, mc;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .done(done), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // External combinational ALU driven by the DUT operands
  always_comb begin
    logic [DW:0] s;
    s = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = 1'b0;
    case (alu_select)
      2'b00:   begin alu_result = s[DW-1:0]; alu_carry = s[DW]; end
      2'b01:   alu_result = alu_a & alu_b;
      2'b10:   alu_result = ~(alu_a & alu_b);
      default: alu_result = ~(alu_a | alu_b);
    endcase
  end

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m[i] = '0;
    mz = 1'b0;
    mc = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] a, input logic [DW-1:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    if (!(Z0 && a == 3'd0)) m[a] = d;
  endtask

  task automatic do_instr(input logic [1:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2);
    logic [DW-1:0] ea, eb, er;
    logic          ec;
    int unsigned   sum;
    ea = m[rs1];
    eb = m[rs2];
    ec = 1'b0;
    case (op)
      2'b00: begin
        sum = int'(ea) + int'(eb);
        er  = DW'(sum % (1 << DW));
        ec  = (sum >= (1 << DW));
      end
      2'b01:   er = ea & eb;
      2'b10:   er = ALL1 ^ (ea & eb);
      default: er = ALL1 ^ (ea | eb);
    endcase
    instr_valid = 1'b1;
    instr = {op, rd, rs1, rs2};
    #1;
    checks++; if (instr_ready !== 1'b1) begin errs++; $display("FAIL instr_ready_idle: got %b want 1", instr_ready); end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL done_issue: got %b want 0", done); end
    checks++; if (alu_a !== ea) begin errs++; $display("FAIL alu_a: got %h want %h", alu_a, ea); end
    checks++; if (alu_b !== eb) begin errs++; $display("FAIL alu_b: got %h want %h", alu_b, eb); end
    checks++; if (alu_select !== op) begin errs++; $display("FAIL alu_select: got %b want %b", alu_select, op); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin errs++; $display("FAIL done_wb: got %b want 1", done); end
    checks++; if (alu_a !== ea || alu_b !== eb) begin errs++; $display("FAIL operand_hold: got %h/%h want %h/%h", alu_a, alu_b, ea, eb); end
    @(posedge clk); #1;
    if (!(Z0 && rd == 3'd0)) m[rd] = er;
    mz = (er == '0);
    mc = ec;
    checks++; if (done !== 1'b0 || ld_ready !== 1'b1) begin errs++; $display("FAIL back_to_idle: done=%b ld_ready=%b want 0/1", done, ld_ready); end
    dbg_addr = rd; #1;
    checks++; if (dbg_data !== m[rd]) begin errs++; $display("FAIL wb_reg r%0d: got %h want %h", rd, dbg_data, m[rd]); end
    checks++; if (zero_flag !== mz) begin errs++; $display("FAIL zero_flag: got %b want %b", zero_flag, mz); end
    checks++; if (carry_flag !== mc) begin errs++; $display("FAIL carry_flag: got %b want %b", carry_flag, mc); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (ld_ready !== 1'b1 || instr_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b/%b want 1/1", ld_ready, instr_ready); end
    checks++; if (alu_a !== '0 || alu_b !== '0 || alu_select !== 2'b00) begin errs++; $display("FAIL rst_alu_regs: got %h/%h/%b want 0", alu_a, alu_b, alu_select); end
    checks++; if (zero_flag !== 1'b0 || carry_flag !== 1'b0) begin errs++; $display("FAIL rst_flags: got z=%b c=%b want 0", zero_flag, carry_flag); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++; if (dbg_data !== '0) begin errs++; $display("FAIL rst_rf r%0d: got %h want 0", i, dbg_data); end
    end
  endtask

  task automatic test_directed();
    do_load(3'd1, 18'd5);
    do_load(3'd2, 18'd3);
    do_instr(2'b00, 3'd3, 3'd1, 3'd2);
    checks++; if (dbg_data !== 18'd8 || carry_flag !== 1'b0 || zero_flag !== 1'b0) begin errs++; $display("FAIL add_5_3: got r3=%h c=%b z=%b want 8/0/0", dbg_data, carry_flag, zero_flag); end
    do_load(3'd1, ALL1);
    do_load(3'd2, 18'd1);
    do_instr(2'b00, 3'd4, 3'd1, 3'd2);
    checks++; if (dbg_data !== '0 || carry_flag !== 1'b1 || zero_flag !== 1'b1) begin errs++; $display("FAIL add_wrap: got r4=%h c=%b z=%b want 0/1/1", dbg_data, carry_flag, zero_flag); end
    do_load(3'd6, 18'd9);
    checks++; if (carry_flag !== 1'b1 || zero_flag !== 1'b1) begin errs++; $display("FAIL flags_hold_on_load: got c=%b z=%b want 1/1", carry_flag, zero_flag); end
    do_instr(2'b10, 3'd5, 3'd1, 3'd1);
    checks++; if (dbg_data !== '0 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin errs++; $display("FAIL nand_ones: got r5=%h z=%b c=%b want 0/1/0", dbg_data, zero_flag, carry_flag); end
    do_load(3'd7, 18'd0);
    do_instr(2'b11, 3'd6, 3'd7, 3'd7);
    checks++; if (dbg_data !== ALL1 || zero_flag !== 1'b0) begin errs++; $display("FAIL nor_zero: got r6=%h z=%b want 3ffff/0", dbg_data, zero_flag); end
    do_instr(2'b00, 3'd2, 3'd2, 3'd2);
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] d;
    d = DW'($urandom);
    ld_valid = 1'b1; ld_addr = 3'd6; ld_data = d;
    instr_valid = 1'b1; instr = {2'b00, 3'd7, 3'd6, 3'd1};
    #1;
    checks++; if (instr_ready !== 1'b0 || ld_ready !== 1'b1) begin errs++; $display("FAIL simul_ready: got instr_ready=%b ld_ready=%b want 0/1", instr_ready, ld_ready); end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    m[6] = d;
    checks++; if (ld_ready !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL simul_instr_held: got ld_ready=%b done=%b want 1/0", ld_ready, done); end
    dbg_addr = 3'd6; #1;
    checks++; if (dbg_data !== d) begin errs++; $display("FAIL simul_load: got %h want %h", dbg_data, d); end
    do_instr(2'b00, 3'd7, 3'd6, 3'd1);
  endtask

  task automatic test_reset_abort();
    do_load(3'd1, 18'd100);
    do_load(3'd2, 18'd23);
    instr_valid = 1'b1; instr = {2'b00, 3'd3, 3'd1, 3'd2};
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    checks++; if (done !== 1'b0 || ld_ready !== 1'b1) begin errs++; $display("FAIL abort_state: got done=%b ld_ready=%b want 0/1", done, ld_ready); end
    dbg_addr = 3'd3; #1;
    checks++; if (dbg_data !== '0) begin errs++; $display("FAIL abort_r3: got %h want 0", dbg_data); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin errs++; $display("FAIL abort_no_wb: got done=%b z=%b c=%b want 0", done, zero_flag, carry_flag); end
  endtask

  task automatic test_reg0();
    do_load(3'd0, 18'd7);
    dbg_addr = 3'd0; #1;
    checks++; if (dbg_data !== (Z0 ? 18'd0 : 18'd7)) begin errs++; $display("FAIL r0_load: got %h want %h", dbg_data, Z0 ? 18'd0 : 18'd7); end
    do_load(3'd1, 18'd20);
    do_load(3'd2, 18'd22);
    do_instr(2'b00, 3'd0, 3'd1, 3'd2);
    checks++; if (dbg_data !== (Z0 ? 18'd0 : 18'd42)) begin errs++; $display("FAIL r0_wb: got %h want %h", dbg_data, Z0 ? 18'd0 : 18'd42); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [DW-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = ALL1;
        default: d = DW'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) begin
        do_load(3'($urandom), d);
      end else begin
        do_instr(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      end
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++; if (dbg_data !== m[i]) begin errs++; $display("FAIL rand_final r%0d: got %h want %h", i, dbg_data, m[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    instr_valid = 1'b0; instr = '0; dbg_addr = '0;
    model_clear();
    test_reset();
    test_directed();
    test_simultaneous();
    test_reset_abort();
    test_reg0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter DATA_W, default 18, SHALL set operand/result width, matching the 18-bit ALU datapath.
REQ-002 Parameter NREGS, default 8, SHALL set register-file depth; address width = clog2(NREGS) = 3.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ld_valid in 1 / ld_addr in 3 / ld_data in DATA_W SHALL form the host register-load port; ld_ready out 1 SHALL accept it.
REQ-006 instr_valid in 1 / instr in 11 SHALL carry {op[10:9], rd[8:6], rs1[5:3], rs2[2:0]}; instr_ready out 1 SHALL accept it.
REQ-007 alu_a out DATA_W, alu_b out DATA_W and alu_select out 2 SHALL drive the ALU; alu_result in DATA_W and alu_carry in 1 SHALL return from it.
REQ-008 done out 1, carry_flag out 1, zero_flag out 1; dbg_addr in 3 / dbg_data out DATA_W SHALL provide a combinational register read.

Function
REQ-009 FSM states IDLE, ISSUE, WB; transitions IDLE->ISSUE on instruction accept, ISSUE->WB unconditionally, WB->IDLE unconditionally.
REQ-010 ld_ready SHALL equal (state==IDLE); a load SHALL write rf[ld_addr]<=ld_data at the accepting edge.
REQ-011 instr_ready SHALL equal (state==IDLE && !ld_valid); a simultaneous load and instruction SHALL take the load, and the instruction SHALL wait.
REQ-012 On accept: alu_a<=rf[rs1], alu_b<=rf[rs2], alu_select<=op, and rd is latched; these registers SHALL hold through ISSUE and WB.
REQ-013 op encoding SHALL be 00 ADD, 01 AND, 10 NAND, 11 NOR, passed unchanged to alu_select.
REQ-014 ISSUE SHALL be a settle cycle with no state writes.
REQ-015 At the edge ending WB: rf[rd]<=alu_result; zero_flag<=(alu_result==0); carry_flag<=alu_carry when op==ADD, else 0.
REQ-016 done SHALL be high exactly during WB (one cycle per instruction).
REQ-017 Latency: accept at edge N, result visible on dbg_data after edge N+2, next accept at edge N+3 at the earliest; throughput SHALL be one instruction per 3 cycles.
REQ-018 rd==rs1 or rd==rs2 SHALL be legal; operands SHALL be the pre-write values.
REQ-019 Flags SHALL hold their values between writebacks and SHALL NOT be changed by loads.

Reset
REQ-020 rst SHALL set state=IDLE, all rf entries=0, alu_a=alu_b=0, alu_select=00, flags=0 and done=0.
REQ-021 rst asserted in ISSUE or WB SHALL abort the instruction with no rf or flag write; rst SHALL take priority over load and accept.

Configuration
REQ-022 With ALU_STAGE_REG0_ZERO_EN defined, rf[0] SHALL read as 0 and writes to it from load or WB SHALL be discarded; flags SHALL still update in WB.
REQ-023 Without ALU_STAGE_REG0_ZERO_EN, rf[0] SHALL be an ordinary register.

Structure
REQ-024 Package alu_pkg SHALL hold DATA_W, the opcode enum (OP_ADD, OP_AND, OP_NAND, OP_NOR), the state enum and the instr field positions.
REQ-025 Sub-module alu_regfile SHALL implement NREGS x DATA_W storage with 1 sync write port and 3 async read ports (rs1, rs2, dbg); write-port muxing between load and WB SHALL stay in alu_operand_stage.

Verification
REQ-026 Load r1=5, r2=3; ADD r3,r1,r2 -> done at WB, r3=8, carry_flag=0, zero_flag=0.
REQ-027 Load r1=0x3FFFF, r2=1; ADD r4 -> r4=0, carry_flag=1, zero_flag=1.
REQ-028 r1=0x3FFFF; NAND r5,r1,r1 -> r5=0, zero_flag=1, carry_flag=0; NOR with 0 operands -> 0x3FFFF, zero_flag=0.
REQ-029 ld_valid and instr_valid together in IDLE -> load written, instr_ready=0 that cycle, instruction accepted next cycle.
REQ-030 rst pulsed in ISSUE of ADD r3 -> r3=0 after reset, no done pulse, state IDLE.
REQ-031 Define ALU_STAGE_REG0_ZERO_EN; load r0=7 and ADD r0,r1,r2 -> dbg_data for r0 = 0; without the macro -> r0=7, then the ADD result.
